// File: rtl/intc_ack_pkg.sv
// Shared types for the interrupt-acknowledge arbiter: acknowledge type, slot state and slot contents.
package intc_ack_pkg;

    typedef enum logic [1:0] {
        ACK_NORMAL = 2'd0,
        ACK_NMI    = 2'd1,
        ACK_ERR    = 2'd2,
        ACK_RSVD   = 2'd3
    } ack_type_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } slot_st_e;

    // Slot index storage is sized for the widest supported IDX_W; narrower indexes are zero-extended.
    localparam int IDX_MAX_W = 16;
    localparam int REG_BITS  = 32;

    typedef struct packed {
        ack_type_e              typ;
        logic [IDX_MAX_W-1:0]   idx;
    } slot_t;

    function automatic logic is_prio(input ack_type_e t);
        return (t == ACK_NMI) || (t == ACK_ERR);
    endfunction

endpackage

// File: rtl/intc_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer moves past
// the winner only when adv is strobed.
module intc_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output logic [1:0]   gnt_id,
    output logic         gnt_vld
);

    logic [1:0] ptr_q, ptr_d;
    logic [2:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = 3'(ptr_q) + 3'(k);
            if (pos >= 3'(N)) pos = pos - 3'(N);
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && req[i] && (pos == 3'(i))) begin
                    gnt[i]  = 1'b1;
                    gnt_id  = 2'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && gnt_vld) begin
            ptr_d = (gnt_id == 2'(N-1)) ? 2'd0 : gnt_id + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/intc_ack_arb.sv
// Arbitrates per-CPU interrupt acknowledges onto one registered clear beat (valid/ready).
// Optional macro INTC_ACK_ARB_NMI_PRIO_EN: held NMI/error slots win over normal ones.
module intc_ack_arb
    import intc_ack_pkg::*;
#(
    parameter int CPU_NUM = 2,
    parameter int REG_NUM = 1,
    parameter int IDX_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CPU_NUM-1:0]               ack_vld_i,
    input  logic [CPU_NUM-1:0][1:0]          ack_type_i,
    input  logic [CPU_NUM-1:0][IDX_W-1:0]    ack_idx_i,
    output logic [CPU_NUM-1:0]               ack_rdy_o,
    output logic                             clr_vld_o,
    input  logic                             clr_rdy_i,
    output logic [1:0]                       clr_cpu_o,
    output logic [1:0]                       clr_type_o,
    output logic [REG_NUM*REG_BITS-1:0]      clr_vec_o,
    output logic [CPU_NUM-1:0]               clr_nmi_o,
    output logic [CPU_NUM-1:0]               clr_err_o,
    output logic                             bad_idx_o
);

    localparam int NRM_NUM = REG_NUM * REG_BITS;

    logic [CPU_NUM-1:0]   held;
    logic [CPU_NUM-1:0]   arb_req;
    logic [CPU_NUM-1:0]   gnt;
    logic [1:0]           gnt_id;
    logic                 gnt_vld;
    logic                 load;
    logic                 arb_adv;
    slot_t [CPU_NUM-1:0]  slot_vec;
    slot_t                sel;

    logic                 clr_vld_q, clr_vld_d;
    logic [1:0]           clr_cpu_q, clr_cpu_d;
    ack_type_e            clr_type_q, clr_type_d;
    logic [NRM_NUM-1:0]   clr_vec_q, clr_vec_d;
    logic [CPU_NUM-1:0]   clr_nmi_q, clr_nmi_d;
    logic [CPU_NUM-1:0]   clr_err_q, clr_err_d;
    logic                 bad_idx_q, bad_idx_d;

    // A beat is loaded whenever the output register is free or being drained this cycle.
    assign load = (!clr_vld_q || clr_rdy_i) && gnt_vld;

    for (genvar gi = 0; gi < CPU_NUM; gi++) begin : g_slot
        slot_st_e st_q, st_d;
        slot_t    slot_q, slot_d;

        always_comb begin
            st_d   = st_q;
            slot_d = slot_q;
            if (st_q == SLOT_HELD) begin
                if (load && gnt[gi]) st_d = SLOT_EMPTY;
            end else if (ack_vld_i[gi] && (ack_type_i[gi] != ACK_RSVD)) begin
                st_d       = SLOT_HELD;
                slot_d.typ = ack_type_e'(ack_type_i[gi]);
                slot_d.idx = IDX_MAX_W'(ack_idx_i[gi]);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q   <= SLOT_EMPTY;
                slot_q <= '0;
            end else begin
                st_q   <= st_d;
                slot_q <= slot_d;
            end
        end

        assign held[gi]      = (st_q == SLOT_HELD);
        assign ack_rdy_o[gi] = (st_q == SLOT_EMPTY);
        assign slot_vec[gi]  = slot_q;
    end

`ifdef INTC_ACK_ARB_NMI_PRIO_EN
    logic [CPU_NUM-1:0] prio_held;
    for (genvar gi = 0; gi < CPU_NUM; gi++) begin : g_prio
        assign prio_held[gi] = held[gi] && is_prio(slot_vec[gi].typ);
    end
    assign arb_req = (|prio_held) ? prio_held : held;
    // Priority grants leave the pointer alone so normal sources keep their turn.
    assign arb_adv = load && (sel.typ == ACK_NORMAL);
`else
    assign arb_req = held;
    assign arb_adv = load;
`endif

    intc_rr_arb #(.N(CPU_NUM)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .adv     (arb_adv),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            if (gnt[i]) sel = slot_vec[i];
        end
    end

    always_comb begin
        clr_vld_d  = clr_vld_q;
        clr_cpu_d  = clr_cpu_q;
        clr_type_d = clr_type_q;
        clr_vec_d  = clr_vec_q;
        clr_nmi_d  = clr_nmi_q;
        clr_err_d  = clr_err_q;
        bad_idx_d  = bad_idx_q;
        if (load) begin
            clr_vld_d  = 1'b1;
            clr_cpu_d  = gnt_id;
            clr_type_d = sel.typ;
            clr_vec_d  = '0;
            clr_nmi_d  = '0;
            clr_err_d  = '0;
            case (sel.typ)
                ACK_NORMAL: begin
                    if (32'(sel.idx) < 32'(NRM_NUM)) begin
                        for (int b = 0; b < NRM_NUM; b++) begin
                            clr_vec_d[b] = (32'(sel.idx) == 32'(b));
                        end
                    end else begin
                        bad_idx_d = 1'b1;
                    end
                end
                ACK_NMI: clr_nmi_d = gnt;
                ACK_ERR: clr_err_d = gnt;
                default: ;
            endcase
        end else if (clr_rdy_i) begin
            clr_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_vld_q  <= 1'b0;
            clr_cpu_q  <= '0;
            clr_type_q <= ACK_NORMAL;
            clr_vec_q  <= '0;
            clr_nmi_q  <= '0;
            clr_err_q  <= '0;
            bad_idx_q  <= 1'b0;
        end else begin
            clr_vld_q  <= clr_vld_d;
            clr_cpu_q  <= clr_cpu_d;
            clr_type_q <= clr_type_d;
            clr_vec_q  <= clr_vec_d;
            clr_nmi_q  <= clr_nmi_d;
            clr_err_q  <= clr_err_d;
            bad_idx_q  <= bad_idx_d;
        end
    end

    assign clr_vld_o  = clr_vld_q;
    assign clr_cpu_o  = clr_cpu_q;
    assign clr_type_o = clr_type_q;
    assign clr_vec_o  = clr_vec_q;
    assign clr_nmi_o  = clr_nmi_q;
    assign clr_err_o  = clr_err_q;
    assign bad_idx_o  = bad_idx_q;

endmodule

// File: tb/tb_intc_ack_arb.sv
// Directed bench for intc_ack_arb (CPU_NUM=4, REG_NUM=1): expected beats are queued as acknowledges
// are driven and compared when each beat handshakes.
module tb_intc_ack_arb;

    localparam int CPU_NUM = 4;
    localparam int REG_NUM = 1;
    localparam int IDX_W   = 8;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [CPU_NUM-1:0]             ack_vld_i;
    logic [CPU_NUM-1:0][1:0]        ack_type_i;
    logic [CPU_NUM-1:0][IDX_W-1:0]  ack_idx_i;
    logic [CPU_NUM-1:0]             ack_rdy_o;
    logic                           clr_vld_o;
    logic                           clr_rdy_i;
    logic [1:0]                     clr_cpu_o;
    logic [1:0]                     clr_type_o;
    logic [REG_NUM*32-1:0]          clr_vec_o;
    logic [CPU_NUM-1:0]             clr_nmi_o;
    logic [CPU_NUM-1:0]             clr_err_o;
    logic                           bad_idx_o;

    intc_ack_arb #(.CPU_NUM(CPU_NUM), .REG_NUM(REG_NUM), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ack_vld_i  (ack_vld_i),
        .ack_type_i (ack_type_i),
        .ack_idx_i  (ack_idx_i),
        .ack_rdy_o  (ack_rdy_o),
        .clr_vld_o  (clr_vld_o),
        .clr_rdy_i  (clr_rdy_i),
        .clr_cpu_o  (clr_cpu_o),
        .clr_type_o (clr_type_o),
        .clr_vec_o  (clr_vec_o),
        .clr_nmi_o  (clr_nmi_o),
        .clr_err_o  (clr_err_o),
        .bad_idx_o  (bad_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cpu;
        logic [1:0]  typ;
        logic [31:0] vec;
        logic [3:0]  nmi;
        logic [3:0]  err;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t model(input int c, input logic [1:0] t, input logic [7:0] idx);
        beat_t b;
        b.cpu = 2'(c);
        b.typ = t;
        b.vec = '0;
        b.nmi = '0;
        b.err = '0;
        if (t == 2'd0 && idx < 8'd32) b.vec = 32'd1 << idx;
        if (t == 2'd1) b.nmi = 4'd1 << c;
        if (t == 2'd2) b.err = 4'd1 << c;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ack(input int c, input logic [1:0] t, input logic [7:0] idx);
        ack_vld_i[c]  = 1'b1;
        ack_type_i[c] = t;
        ack_idx_i[c]  = idx;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},  64'(ack_rdy_o),  64'hF);
        chk({tag, "_vld"},  64'(clr_vld_o),  64'd0);
        chk({tag, "_cpu"},  64'(clr_cpu_o),  64'd0);
        chk({tag, "_type"}, 64'(clr_type_o), 64'd0);
        chk({tag, "_vec"},  64'(clr_vec_o),  64'd0);
        chk({tag, "_nmi"},  64'(clr_nmi_o),  64'd0);
        chk({tag, "_err"},  64'(clr_err_o),  64'd0);
        chk({tag, "_bad"},  64'(bad_idx_o),  64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || clr_vld_o) && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle"},    64'(clr_vld_o),    64'd0);
    endtask

    // Beat monitor: every handshake must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && clr_vld_o && clr_rdy_i) begin
            $display("beat cpu=%0d type=%0d vec=%h nmi=%b err=%b bad=%0d",
                     clr_cpu_o, clr_type_o, clr_vec_o, clr_nmi_o, clr_err_o, bad_idx_o);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_cpu",  64'(clr_cpu_o),  64'(e.cpu));
                chk("beat_type", 64'(clr_type_o), 64'(e.typ));
                chk("beat_vec",  64'(clr_vec_o),  64'(e.vec));
                chk("beat_nmi",  64'(clr_nmi_o),  64'(e.nmi));
                chk("beat_err",  64'(clr_err_o),  64'(e.err));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        clr_rdy_i  = 1'b1;
        ack_vld_i  = '0;
        ack_type_i = '0;
        ack_idx_i  = '0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // All four CPUs at once: drain in order 0..3 back to back.
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(model(c, 2'd0, 8'(c)));
            drive_ack(c, 2'd0, 8'(c));
        end
        step();
        ack_vld_i = '0;
        chk("all4_rdy_n1", 64'(ack_rdy_o), 64'h0);
        chk("all4_vld_n1", 64'(clr_vld_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("all4_burst_vld", 64'(clr_vld_o), 64'd1);
            chk("all4_burst_cpu", 64'(clr_cpu_o), 64'(k));
        end
        drain("all4");

        // Single acknowledge latency: CPU1 idx 5.
        exp_q.push_back(model(1, 2'd0, 8'd5));
        drive_ack(1, 2'd0, 8'd5);
        step();
        ack_vld_i = '0;
        chk("single_rdy_n1", 64'(ack_rdy_o[1]), 64'd0);
        chk("single_vld_n1", 64'(clr_vld_o),    64'd0);
        step();
        chk("single_rdy_n2", 64'(ack_rdy_o[1]), 64'd1);
        chk("single_vld_n2", 64'(clr_vld_o),    64'd1);
        chk("single_cpu",    64'(clr_cpu_o),    64'd1);
        chk("single_vec",    64'(clr_vec_o),    64'h20);
        drain("single");

        // Pointer now 2: CPU3 is served before CPU1.
        exp_q.push_back(model(3, 2'd0, 8'd7));
        exp_q.push_back(model(1, 2'd0, 8'd9));
        drive_ack(1, 2'd0, 8'd9);
        drive_ack(3, 2'd0, 8'd7);
        step();
        ack_vld_i = '0;
        drain("rr_order");

        // Backpressure with CPU2 NMI; a second CPU2 NMI is held back while the first is stuck.
        clr_rdy_i = 1'b0;
        exp_q.push_back(model(2, 2'd1, 8'd0));
        drive_ack(2, 2'd1, 8'd0);
        step();
        chk("bp_rdy_n1", 64'(ack_rdy_o[2]), 64'd0);
        step();
        chk("bp_rdy_n2", 64'(ack_rdy_o[2]), 64'd1);
        chk("bp_vld_n2", 64'(clr_vld_o),    64'd1);
        chk("bp_nmi_n2", 64'(clr_nmi_o),    64'h4);
        exp_q.push_back(model(2, 2'd1, 8'd0));
        step();
        ack_vld_i = '0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_hold_rdy", 64'(ack_rdy_o[2]), 64'd0);
            chk("bp_hold_vld", 64'(clr_vld_o),    64'd1);
            chk("bp_hold_nmi", 64'(clr_nmi_o),    64'h4);
            chk("bp_hold_cpu", 64'(clr_cpu_o),    64'd2);
            if (k < 3) step();
        end
        clr_rdy_i = 1'b1;
        drain("bp");

        // Out-of-range normal index.
        chk("oor_bad_before", 64'(bad_idx_o), 64'd0);
        exp_q.push_back(model(0, 2'd0, 8'd40));
        drive_ack(0, 2'd0, 8'd40);
        step();
        ack_vld_i = '0;
        step();
        chk("oor_vld", 64'(clr_vld_o), 64'd1);
        chk("oor_vec", 64'(clr_vec_o), 64'd0);
        chk("oor_bad", 64'(bad_idx_o), 64'd1);
        drain("oor");
        chk("oor_bad_sticky", 64'(bad_idx_o), 64'd1);

        // Move the pointer to 0, then hold CPU0 normal and CPU3 error together.
        exp_q.push_back(model(3, 2'd0, 8'd12));
        drive_ack(3, 2'd0, 8'd12);
        step();
        ack_vld_i = '0;
        drain("prio_prep");
`ifdef INTC_ACK_ARB_NMI_PRIO_EN
        exp_q.push_back(model(3, 2'd2, 8'd0));
        exp_q.push_back(model(0, 2'd0, 8'd1));
`else
        exp_q.push_back(model(0, 2'd0, 8'd1));
        exp_q.push_back(model(3, 2'd2, 8'd0));
`endif
        drive_ack(0, 2'd0, 8'd1);
        drive_ack(3, 2'd2, 8'd0);
        step();
        ack_vld_i = '0;
        drain("prio");
        chk("prio_bad_sticky", 64'(bad_idx_o), 64'd1);

        // Reset while three slots are held and a beat is stalled.
        clr_rdy_i = 1'b0;
        for (int c = 0; c < 4; c++) drive_ack(c, 2'd0, 8'(10 + c));
        step();
        ack_vld_i = '0;
        step();
        chk("rstmid_vld", 64'(clr_vld_o), 64'd1);
        chk("rstmid_held", 64'($countones(ack_rdy_o)), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset("rstmid");
        exp_q.delete();
        step();
        rst       = 1'b0;
        clr_rdy_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_quiet", 64'(clr_vld_o), 64'd0);
        end

        // Fresh traffic after reset.
        exp_q.push_back(model(2, 2'd0, 8'd31));
        drive_ack(2, 2'd0, 8'd31);
        step();
        ack_vld_i = '0;
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intc_ack_arb.md
Name: intc_ack_arb

Overview:
- Arbitrates interrupt-acknowledge events from up to CPU_NUM CPU interfaces onto the single shared clear path of the interrupt pending/select logic.
- Each CPU's acknowledge is held in a one-deep slot. Slots are granted round-robin, and the winner drives a registered clear beat (index, type, one-hot clear vector) under a valid/ready handshake.
- Simultaneous acknowledges never collide or get lost; a full slot backpressures its CPU.

Parameters:
- CPU_NUM, 2, number of CPU acknowledge ports (1..4).
- REG_NUM, 1, number of 32-bit normal-interrupt registers; normal sources = REG_NUM*32.
- IDX_W, 8, width of the acknowledged source index (must satisfy 2**IDX_W >= REG_NUM*32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ack_vld_i  in  CPU_NUM  per-CPU acknowledge valid.
- ack_type_i  in  [CPU_NUM-1:0][1:0]  per-CPU type: 0 normal, 1 NMI, 2 error, 3 reserved.
- ack_idx_i  in  [CPU_NUM-1:0][IDX_W-1:0]  per-CPU normal source index (ignored unless type is normal).
- ack_rdy_o  out  CPU_NUM  per-CPU slot empty; the acknowledge is accepted when vld & rdy.
- clr_vld_o  out  1  clear beat valid.
- clr_rdy_i  in  1  pending logic accepts the beat.
- clr_cpu_o  out  2  CPU id of the beat.
- clr_type_o  out  2  type of the beat.
- clr_vec_o  out  REG_NUM*32  one-hot clear for normal type; all zero otherwise.
- clr_nmi_o  out  CPU_NUM  one-hot CPU bit when the type is NMI.
- clr_err_o  out  CPU_NUM  one-hot CPU bit when the type is error.
- bad_idx_o  out  1  sticky flag: a normal index >= REG_NUM*32 was accepted.

Behaviour:
- Reset (asynchronous), all outputs and state cleared:
  - ack_rdy_o = all 1; clr_vld_o = 0; clr_cpu_o, clr_type_o, clr_vec_o, clr_nmi_o, clr_err_o = 0; bad_idx_o = 0.
  - All slots EMPTY; RR pointer = 0.
- Per-slot FSM, EMPTY -> HELD -> EMPTY:
  - EMPTY -> HELD on ack_vld_i & ack_rdy_o; the slot captures type and idx.
  - HELD -> EMPTY on the cycle its slot is granted into the output register.
  - ack_rdy_o = (slot EMPTY), registered; there is no same-cycle refill of a slot being granted.
  - Type 3 is accepted and silently dropped; the slot stays EMPTY.
- Output register:
  - Loads when (!clr_vld_o | clr_rdy_i) and at least one slot is HELD.
  - Otherwise, clr_vld_o clears when clr_rdy_i is high.
  - Content holds stable while clr_vld_o & !clr_rdy_i.
- Grant:
  - Round-robin among HELD slots, starting at the RR pointer.
  - After a grant to CPU g, pointer = (g+1) mod CPU_NUM.
- Latency:
  - Acknowledge accepted at edge N -> slot HELD in cycle N+1 -> clr_vld_o high in cycle N+2 when the output register is free.
  - Full throughput: one beat per cycle while clr_rdy_i = 1.
- Decode:
  - clr_vec_o[idx] = 1 only when type is normal and idx < REG_NUM*32.
  - Out-of-range idx produces a beat with zero vector and sets bad_idx_o; bad_idx_o clears only on reset.
- Simultaneous events:
  - All CPUs acknowledging in the same cycle are all captured; beats drain in RR order.
  - A slot being granted and its CPU re-asserting in the same cycle: the re-assert is not accepted (rdy = 0) and is taken the next cycle.
- Reset mid-operation: held slots and any pending beat are discarded; no beat is emitted after reset deasserts until a new acknowledge arrives.

Optional Feature:
- INTC_ACK_ARB_NMI_PRIO_EN
  - Defined: a HELD slot of type NMI or error wins over normal slots. Among several such slots, RR order applies. The pointer advances only on normal grants.
  - Undefined: pure round-robin regardless of type.

Decomposition:
- Package intc_ack_pkg:
  - ack_type_e enum (ACK_NORMAL=0, ACK_NMI=1, ACK_ERR=2, ACK_RSVD=3).
  - Slot struct {type, idx}.
  - Localparam NRM_NUM = REG_NUM*32.
- Sub-module intc_rr_arb: CPU_NUM-wide round-robin arbiter with req vector, advance strobe, one-hot grant and encoded grant id.

Test Plan (CPU_NUM=4, REG_NUM=1):
- Single acknowledge: CPU1 normal idx 5 at edge N -> clr_vld_o = 1 in cycle N+2, clr_cpu_o = 1, clr_vec_o = 0x0000_0020, ack_rdy_o[1] = 0 in cycle N+1 only.
- All four CPUs acknowledge normal idx 0..3 in one cycle with clr_rdy_i = 1 -> four consecutive beats in CPU order 0,1,2,3; then the pointer is 0.
- Backpressure: clr_rdy_i = 0 for 5 cycles with CPU2 NMI pending -> the beat holds with clr_nmi_o = 4'b0100 stable. A second CPU2 acknowledge is blocked (ack_rdy_o[2] = 0) until the grant.
- Out-of-range: CPU0 normal idx 40 -> beat with clr_vec_o = 0, bad_idx_o = 1 and sticky until rst.
- NMI priority (macro defined): CPU0 normal and CPU3 error are HELD together -> CPU3 beat first (clr_err_o = 4'b1000). With the macro undefined -> CPU0 first.
- Reset mid-operation: rst pulsed while 3 slots are HELD and clr_vld_o = 1 -> all outputs are at reset values immediately; no beat appears afterwards.
